// File: rtl/bigseg_pkg.sv
// Shared constants for the big-segment table: geometry, per-group field positions
// and the update-writer FSM encoding. The lookup stage imports the same field constants.
package bigseg_pkg;

  localparam int BIG_SEGMENT_NUM     = 184;
  localparam int BIG_SEGMENT_BITLENS = 8;
  localparam int ENTRY_W             = 60;
  localparam int GROUP_NUM           = 5;
  localparam int GROUP_IDX_W         = 11;
  localparam int SEG_ADDR_W          = 11;

  localparam int G0_IDX_MSB = 59;
  localparam int G0_IDX_LSB = 49;
  localparam int G0_FLAG    = 48;
  localparam int G1_IDX_MSB = 47;
  localparam int G1_IDX_LSB = 37;
  localparam int G1_FLAG    = 36;
  localparam int G2_IDX_MSB = 35;
  localparam int G2_IDX_LSB = 25;
  localparam int G2_FLAG    = 24;
  localparam int G3_IDX_MSB = 23;
  localparam int G3_IDX_LSB = 13;
  localparam int G3_FLAG    = 12;
  localparam int G4_IDX_MSB = 11;
  localparam int G4_IDX_LSB = 1;
  localparam int G4_FLAG    = 0;

  typedef enum logic [2:0] {
    ST_CLR  = 3'd0,
    ST_IDLE = 3'd1,
    ST_RD   = 3'd2,
    ST_MOD  = 3'd3,
    ST_WR   = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

endpackage

// File: rtl/bigseg_entry_merge.sv
// Combinational merge of one group's index/flag into a table entry, or a full
// clear of the entry when clear_i is set.
module bigseg_entry_merge
  import bigseg_pkg::*;
(
  input  logic [ENTRY_W-1:0]     entry_i,
  input  logic [2:0]             group_i,
  input  logic [GROUP_IDX_W-1:0] index_i,
  input  logic                   big_i,
  input  logic                   clear_i,
  output logic [ENTRY_W-1:0]     merged_o
);

  // Replace the selected group's fields; out-of-range groups never reach here.
  always_comb begin
    merged_o = entry_i;
    if (clear_i) begin
      merged_o = '0;
    end else begin
      case (group_i)
        3'd0: begin
          merged_o[G0_IDX_MSB:G0_IDX_LSB] = index_i;
          merged_o[G0_FLAG]               = big_i;
        end
        3'd1: begin
          merged_o[G1_IDX_MSB:G1_IDX_LSB] = index_i;
          merged_o[G1_FLAG]               = big_i;
        end
        3'd2: begin
          merged_o[G2_IDX_MSB:G2_IDX_LSB] = index_i;
          merged_o[G2_FLAG]               = big_i;
        end
        3'd3: begin
          merged_o[G3_IDX_MSB:G3_IDX_LSB] = index_i;
          merged_o[G3_FLAG]               = big_i;
        end
        3'd4: begin
          merged_o[G4_IDX_MSB:G4_IDX_LSB] = index_i;
          merged_o[G4_FLAG]               = big_i;
        end
        default: merged_o = entry_i;
      endcase
    end
  end

endmodule

// File: rtl/bigseg_update_writer.sv
// Write-side engine for the big-segment table: read-modify-write on a local shadow
// copy, mirrored to the lookup stage through single-cycle we/din/segment_index writes.
module bigseg_update_writer
  import bigseg_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           upd_valid,
  output logic                           upd_ready,
  input  logic [BIG_SEGMENT_BITLENS-1:0] upd_seg_index,
  input  logic [2:0]                     upd_group,
  input  logic [GROUP_IDX_W-1:0]         upd_group_index,
  input  logic                           upd_big,
  input  logic                           upd_clear,
  output logic                           we,
  output logic [ENTRY_W-1:0]             din,
  output logic [SEG_ADDR_W-1:0]          segment_index,
  output logic                           done,
  output logic                           err,
  output logic                           init_busy
);

  localparam logic [BIG_SEGMENT_BITLENS-1:0] LAST_SEG = 8'(BIG_SEGMENT_NUM - 1);
  localparam logic [BIG_SEGMENT_BITLENS-1:0] SEG_LIM  = 8'(BIG_SEGMENT_NUM);
  localparam logic [2:0]                     GRP_MAX  = 3'(GROUP_NUM - 1);

  state_e                         state_q;
  logic [BIG_SEGMENT_BITLENS-1:0] clr_cnt_q;
  logic [BIG_SEGMENT_BITLENS-1:0] req_seg_q;
  logic [2:0]                     req_group_q;
  logic [GROUP_IDX_W-1:0]         req_index_q;
  logic                           req_big_q;
  logic                           req_clear_q;
  logic [ENTRY_W-1:0]             rd_data_q;
  logic [ENTRY_W-1:0]             merged_d;
  logic                           we_q;
  logic [ENTRY_W-1:0]             din_q;
  logic [SEG_ADDR_W-1:0]          seg_idx_q;
  logic                           done_q;
  logic                           err_q;
  logic [ENTRY_W-1:0]             shadow_q [BIG_SEGMENT_NUM];

  assign upd_ready     = (state_q == ST_IDLE);
  assign init_busy     = (state_q == ST_CLR);
  assign we            = we_q;
  assign din           = din_q;
  assign segment_index = seg_idx_q;
  assign done          = done_q;
  assign err           = err_q;

  bigseg_entry_merge u_merge (
    .entry_i  (rd_data_q),
    .group_i  (req_group_q),
    .index_i  (req_index_q),
    .big_i    (req_big_q),
    .clear_i  (req_clear_q),
    .merged_o (merged_d)
  );

  // Shadow table; writes are gated by reset so a dropped request never lands here.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_CLR) begin
      shadow_q[clr_cnt_q] <= '0;
    end else if (!rst && state_q == ST_WR) begin
      shadow_q[req_seg_q] <= din_q;
    end
    if (state_q == ST_RD) begin
      rd_data_q <= shadow_q[req_seg_q];
    end
  end

  // Control FSM with registered write-port and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLR : ST_IDLE;
      clr_cnt_q   <= '0;
      req_seg_q   <= '0;
      req_group_q <= 3'd0;
      req_index_q <= '0;
      req_big_q   <= 1'b0;
      req_clear_q <= 1'b0;
      we_q        <= 1'b0;
      din_q       <= '0;
      seg_idx_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_CLR: begin
          we_q      <= 1'b1;
          din_q     <= '0;
          seg_idx_q <= {3'b000, clr_cnt_q};
          if (clr_cnt_q == LAST_SEG) begin
            clr_cnt_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            clr_cnt_q <= clr_cnt_q + 8'd1;
          end
        end
        ST_IDLE: begin
          if (upd_valid) begin
            req_seg_q   <= upd_seg_index;
            req_group_q <= upd_group;
            req_index_q <= upd_group_index;
            req_big_q   <= upd_big;
            req_clear_q <= upd_clear;
            if (upd_seg_index >= SEG_LIM || (upd_group > GRP_MAX && !upd_clear)) begin
              err_q   <= 1'b1;
              state_q <= ST_ERR;
            end else begin
              state_q <= ST_RD;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RD:  state_q <= ST_MOD;
        ST_MOD: begin
          din_q     <= merged_d;
          seg_idx_q <= {3'b000, req_seg_q};
          we_q      <= 1'b1;
          done_q    <= 1'b1;
          state_q   <= ST_WR;
        end
        ST_WR:   state_q <= ST_IDLE;
        ST_ERR:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bigseg_update_writer.sv
// Directed bench for bigseg_update_writer: a reference table model feeds a queue of
// expected lookup-table writes that a monitor pops and compares as writes appear.
module tb_bigseg_update_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [7:0]  upd_seg_index = 8'd0;
  logic [2:0]  upd_group = 3'd0;
  logic [10:0] upd_group_index = 11'd0;
  logic        upd_big = 1'b0;
  logic        upd_clear = 1'b0;
  logic        we;
  logic [59:0] din;
  logic [10:0] segment_index;
  logic        done;
  logic        err;
  logic        init_busy;

  typedef struct {
    logic [10:0] addr;
    logic [59:0] data;
    logic        dn;
  } exp_t;

  exp_t        exp_q[$];
  logic [59:0] model [184];
  int          checks = 0;
  int          errors = 0;
  int          exp_err = 0;
  int          seen_err = 0;
  logic [59:0] last_din = 60'd0;
  logic [10:0] last_addr = 11'd0;

  bigseg_update_writer #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_seg_index(upd_seg_index), .upd_group(upd_group),
    .upd_group_index(upd_group_index), .upd_big(upd_big), .upd_clear(upd_clear),
    .we(we), .din(din), .segment_index(segment_index), .done(done), .err(err),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  // Write monitor: every write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (err === 1'b1) seen_err++;
      if (we === 1'b1) begin
        last_din  = din;
        last_addr = segment_index;
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_write addr=%0d din=%h", segment_index, din);
        end
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          assert (segment_index === e.addr && din === e.data && done === e.dn) else begin
            errors++;
            $error("FAIL write got addr=%0d din=%h done=%b exp addr=%0d din=%h done=%b",
                   segment_index, din, done, e.addr, e.data, e.dn);
          end
        end
      end else begin
        checks++;
        assert (done === 1'b0) else begin
          errors++;
          $error("FAIL done_without_we got=%b exp=0", done);
        end
      end
    end
  end

  task automatic push_sweep();
    for (int i = 0; i < 184; i++) begin
      exp_t e;
      e.addr = 11'(i);
      e.data = 60'd0;
      e.dn   = 1'b0;
      exp_q.push_back(e);
      model[i] = 60'd0;
    end
  endtask

  task automatic check_sweep();
    int n = 0;
    while (init_busy === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    checks++;
    assert (n == 184) else begin
      errors++;
      $error("FAIL init_busy_cycles got=%0d exp=184", n);
    end
    checks++;
    assert (upd_ready === 1'b1) else begin
      errors++;
      $error("FAIL ready_after_sweep got=%b exp=1", upd_ready);
    end
  endtask

  task automatic do_req(input logic [7:0] s, input logic [2:0] g, input logic [10:0] ix,
                        input logic b, input logic c);
    int n = 0;
    while (upd_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    assert (upd_ready === 1'b1) else begin
      errors++;
      $error("FAIL ready_timeout got=%b exp=1", upd_ready);
    end
    upd_valid = 1'b1; upd_seg_index = s; upd_group = g;
    upd_group_index = ix; upd_big = b; upd_clear = c;
    @(posedge clk);
    if (s >= 8'd184 || (g > 3'd4 && !c)) begin
      exp_err++;
    end else begin
      exp_t        e;
      logic [59:0] v;
      logic [59:0] mask;
      logic [59:0] fld;
      int          sh;
      v = model[s];
      if (c) begin
        v = 60'd0;
      end else begin
        sh   = (4 - int'(g)) * 12;
        mask = 60'hFFF << sh;
        fld  = 60'({ix, b}) << sh;
        v    = (v & ~mask) | fld;
      end
      model[s] = v;
      e.addr = {3'b000, s};
      e.data = v;
      e.dn   = 1'b1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic check_last(input string tag, input logic [10:0] a, input logic [59:0] d);
    repeat (5) @(negedge clk);
    #1;
    checks++;
    assert (last_addr === a && last_din === d) else begin
      errors++;
      $error("FAIL %s got addr=%0d din=%h exp addr=%0d din=%h", tag, last_addr, last_din, a, d);
    end
  endtask

  initial begin
    push_sweep();
    repeat (2) @(negedge clk);
    checks++;
    assert (we === 1'b0 && done === 1'b0 && err === 1'b0 && din === 60'd0 &&
            segment_index === 11'd0 && upd_ready === 1'b0) else begin
      errors++;
      $error("FAIL reset_outputs got we=%b done=%b err=%b din=%h idx=%0d rdy=%b exp all 0",
             we, done, err, din, segment_index, upd_ready);
    end
    rst = 1'b0;
    check_sweep();

    do_req(8'd5, 3'd0, 11'h123, 1'b0, 1'b0);
    check_last("g0_write", 11'd5, {11'h123, 1'b0, 48'd0});
    do_req(8'd5, 3'd4, 11'h7FF, 1'b1, 1'b0);
    check_last("g4_merge", 11'd5, {11'h123, 1'b0, 36'd0, 11'h7FF, 1'b1});

    do_req(8'd184, 3'd0, 11'h001, 1'b0, 1'b0);
    checks++;
    assert (err === 1'b1 && we === 1'b0) else begin
      errors++;
      $error("FAIL err_seg got err=%b we=%b exp err=1 we=0", err, we);
    end
    @(negedge clk);
    checks++;
    assert (upd_ready === 1'b1 && err === 1'b0) else begin
      errors++;
      $error("FAIL ready_after_err got rdy=%b err=%b exp rdy=1 err=0", upd_ready, err);
    end
    do_req(8'd7, 3'd5, 11'h0AA, 1'b0, 1'b0);
    checks++;
    assert (err === 1'b1) else begin
      errors++;
      $error("FAIL err_group got=%b exp=1", err);
    end
    do_req(8'd9, 3'd2, 11'h055, 1'b1, 1'b0);
    check_last("after_err", 11'd9, {24'd0, 11'h055, 1'b1, 24'd0});

    do_req(8'd5, 3'd6, 11'h3FF, 1'b1, 1'b1);
    check_last("clear", 11'd5, 60'd0);
    do_req(8'd5, 3'd1, 11'h2AB, 1'b1, 1'b0);
    check_last("g1_after_clear", 11'd5, {12'd0, 11'h2AB, 1'b1, 36'd0});

    do_req(8'd183, 3'd3, 11'h400, 1'b1, 1'b0);
    check_last("last_entry", 11'd183, {36'd0, 11'h400, 1'b1, 12'd0});
    for (int i = 0; i < 24; i++) begin
      do_req(8'($urandom_range(0, 7)), 3'($urandom_range(0, 4)),
             11'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
    end
    repeat (6) @(negedge clk);

    // Reset lands on the MOD edge: the in-flight request must vanish.
    upd_valid = 1'b1; upd_seg_index = 8'd5; upd_group = 3'd2;
    upd_group_index = 11'h111; upd_big = 1'b1; upd_clear = 1'b0;
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    push_sweep();
    @(negedge clk);
    checks++;
    assert (we === 1'b0 && done === 1'b0) else begin
      errors++;
      $error("FAIL reset_in_mod got we=%b done=%b exp 0 0", we, done);
    end
    rst = 1'b0;
    check_sweep();
    do_req(8'd5, 3'd3, 11'h001, 1'b0, 1'b0);
    check_last("post_reset", 11'd5, {36'd0, 11'h001, 1'b0, 12'd0});

    repeat (4) @(negedge clk);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL missing_writes got=%0d pending exp=0", exp_q.size());
    end
    checks++;
    assert (seen_err == exp_err) else begin
      errors++;
      $error("FAIL err_count got=%0d exp=%0d", seen_err, exp_err);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bigseg_update_writer.md
Name: bigseg_update_writer

Overview:
- Write-side engine for the subset big-segment table held inside the lookup stage.
- Accepts per-group update requests and does read-modify-write on a local shadow copy of the table. The lookup table has no read port, so the shadow is the only readable copy.
- Issues single-cycle we/din/segment_index writes that keep both copies identical.
- Sits between the control/update path and the lookup stage's write port.

Parameters:
- BIG_SEGMENT_NUM, 184, number of table entries.
- BIG_SEGMENT_BITLENS, 8, width of the entry index.
- ENTRY_W, 60, entry width: 5 groups x (11-bit index + 1-bit flag).
- CLEAR_ON_RESET, 1, 1 = after reset, sweep-write zero to every entry.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- upd_valid  in  1  update request valid.
- upd_ready  out  1  engine can accept a request.
- upd_seg_index  in  8  target entry.
- upd_group  in  3  target group, 0..4.
- upd_group_index  in  11  new group index value.
- upd_big  in  1  new big/small flag for that group.
- upd_clear  in  1  1 = zero the whole entry; group, index and big are ignored.
- we  out  1  write strobe to the lookup table.
- din  out  60  entry written.
- segment_index  out  11  write address; bits [10:8] are always 0.
- done  out  1  one-cycle pulse when a request's write is issued.
- err  out  1  one-cycle pulse when a request is rejected.
- init_busy  out  1  high during the post-reset clear sweep.

Behaviour:
- Entry layout:
  - G0 index [59:49], flag [48].
  - G1 index [47:37], flag [36].
  - G2 index [35:25], flag [24].
  - G3 index [23:13], flag [12].
  - G4 index [11:1], flag [0].
  - Flag 1 means big group.
- Shadow: 184x60 distributed RAM, synchronous read, written only in WR and CLR.
- FSM states: CLR, IDLE, RD, MOD, WR, ERR.
- Reset:
  - State goes to CLR if CLEAR_ON_RESET, else IDLE.
  - Outputs reset: we=0, din=0, segment_index=0, done=0, err=0.
  - upd_ready=0 while in CLR; init_busy=1 in CLR.
  - A reset mid-request drops the request with no write and no done.
- CLR:
  - Counter runs 0..183; each cycle drives we=1, din=0, segment_index=counter and writes the shadow.
  - After entry 183 is written, next state is IDLE.
  - The sweep takes exactly 184 cycles; upd_valid is ignored throughout.
- IDLE:
  - upd_ready=1.
  - Accept on upd_valid && upd_ready at edge T and latch all request fields.
  - If upd_seg_index >= 184, or upd_group > 4 with upd_clear=0, go to ERR; otherwise go to RD.
- RD (T+1): read shadow[seg].
- MOD (T+2):
  - Merged entry = read data with the selected group's 11-bit index and flag replaced by the request values.
  - If upd_clear=1, merged entry = 0.
  - Register the merged entry into din.
- WR (T+3):
  - we=1 and done=1 for exactly one cycle; segment_index = {3'b0, seg}.
  - Shadow is written with the same data.
  - Next state IDLE, so upd_ready is high at T+4. Throughput is one request per 4 cycles.
- ERR: err=1 for one cycle, we stays 0, next state IDLE.
- we and din are registered. din holds its last value when we=0.
- Back-to-back requests to the same entry: the second read happens after the first write, so no bypass is needed.
- Widths: upd_group_index is written verbatim (11 bits), with no truncation or sign handling.

Decomposition:
- Shared package bigseg_pkg holds:
  - BIG_SEGMENT_NUM, BIG_SEGMENT_BITLENS, ENTRY_W, GROUP_NUM=5.
  - Field MSB/LSB constants for each group index and flag.
  - FSM state encoding.
- The lookup stage imports the same field constants.
- One sub-module: bigseg_entry_merge, purely combinational (entry, group, index, big, clear -> merged entry).

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> init_busy high for 184 cycles; we=1 with din=0 at addresses 0..183 in order; then upd_ready=1.
- Request seg=5, group=0, idx=0x123, big=0 -> one cycle after MOD, we=1 with segment_index=5 and din[59:49]=0x123, din[48]=0, other bits 0; done coincides with we.
- Then seg=5, group=4, idx=0x7FF, big=1 -> din = {0x123,0,36'b0,0x7FF,1}; G0 field preserved and bit 12 untouched.
- seg=184 or group=5 -> err pulse, no we, upd_ready back high next cycle; a following valid request still completes.
- upd_clear on seg=5 -> din=0 at address 5; then a group 1 update on seg=5 shows only the G1 field set.
- Assert rst during MOD -> no we, no done; the clear sweep restarts from address 0.
